instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Upstream feeder for the cpu block. Holds a small program RAM and issues one instruction at a time to the cpu.
- Per instruction: drives `cpu_in`, pulses `cpu_load`, pulses `cpu_s`, then waits for the cpu's `w` handshake to fall and rise again before advancing the PC.
- Lets lab programs run end-to-end without hand-toggling `load` and `s`.

Parameters:
- AW, 4, program RAM address width.
- DEPTH, 16, number of 16-bit program words; must equal 2**AW.
- ACK_TIMEOUT, 4, cycles allowed for `cpu_w` to fall after `cpu_s`.

Ports:
- clk  input  1  rising-edge clock shared with cpu.
- reset  input  1  asynchronous, active-high; returns FSM to IDLE.
- start  input  1  begin execution at PC 0; sampled in IDLE, DONE, ERR only.
- prog_we  input  1  program RAM write enable; honoured only in IDLE, DONE, ERR.
- prog_addr  input  AW  program RAM write address.
- prog_data  input  16  program RAM write data.
- cpu_w  input  1  cpu wait flag (1 = cpu idle in its Wait state).
- cpu_in  output  16  instruction word to cpu `in`; equals mem[pc] combinationally.
- cpu_load  output  1  one-cycle pulse loading the cpu instruction register.
- cpu_s  output  1  one-cycle pulse starting cpu execution.
- pc  output  AW  address of current instruction.
- busy  output  1  high in FETCH, ISSUE, WAIT_ACK, WAIT_DONE.
- done  output  1  high in DONE.
- err  output  1  high in ERR.

Behaviour:
- Clock and reset: single clock `clk`. `reset` is asynchronous and active-high.
- Reset values: state IDLE, pc 0, cpu_load 0, cpu_s 0, busy 0, done 0, err 0, timeout counter 0. RAM contents are not reset.
- Outputs `cpu_load`, `cpu_s`, `busy`, `done` and `err` are Moore decodes of state.
- IDLE:
  - start=1 → FETCH, pc←0.
  - prog_we=1 writes mem[prog_addr]←prog_data at the clock edge.
- FETCH:
  - If mem[pc][15:13]==3'b111 (HALT) → DONE; no load pulse is issued.
  - Otherwise cpu_load=1 for this cycle → ISSUE.
- ISSUE: cpu_s=1 for exactly one cycle → WAIT_ACK; timeout counter cleared.
- WAIT_ACK:
  - cpu_w==0 → WAIT_DONE.
  - Otherwise the counter increments. When the counter reaches ACK_TIMEOUT-1 with cpu_w still 1 → ERR.
- WAIT_DONE: on cpu_w==1:
  - If pc==DEPTH-1 → DONE. pc holds; no wrap.
  - Otherwise pc←pc+1 → FETCH.
- DONE: start=1 → FETCH with pc←0; prog_we is honoured.
- ERR: sticky. Only start (pc←0 → FETCH) or reset leaves it; prog_we is honoured.
- Per-instruction latency with a normal cpu response: FETCH + ISSUE + 1 cycle WAIT_ACK + N cycles of cpu execution in WAIT_DONE.
- Simultaneous events:
  - start and prog_we in the same cycle: the write occurs, and the FSM starts with pc←0. If prog_addr==0, FETCH reads the newly written word.
  - prog_we while busy is ignored; RAM is unchanged.
  - start while busy is ignored.
- Reset mid-operation: immediate return to IDLE. cpu_s and cpu_load drop asynchronously. The cpu must be reset by the same `reset`.
- Unused state encodings → IDLE.

Optional Feature:
- Macro: `INSTR_SEQ_STEP_EN`.
- When defined:
  - Adds input port `step` (1 bit).
  - WAIT_DONE, on cpu_w==1, moves to PAUSE instead of FETCH; PAUSE keeps busy=1.
  - PAUSE leaves on a step rising edge (edge detected internally): pc←pc+1 → FETCH.
  - The pc==DEPTH-1 → DONE rule is checked before entering PAUSE.
- When undefined: no `step` port, no PAUSE state; free-running as described above.

Decomposition:
- Package `seq_pkg`:
  - state enum: IDLE, FETCH, ISSUE, WAIT_ACK, WAIT_DONE, DONE, ERR, PAUSE.
  - HALT_OPCODE = 3'b111.
  - Opcode field slice constants [15:13].
- Sub-module `prog_ram`:
  - DEPTH×16 array, synchronous write, asynchronous read.
  - Instantiated once; its read address is pc.

Test Plan:
- Load mem[0]=16'hD007 (MOV R0,#7) and mem[1]=16'hE000, then pulse start. Model cpu drops w 1 cycle after s and raises it 3 cycles later.
  - Expect: one cpu_load with cpu_in=16'hD007, then one cpu_s.
  - Expect: at pc=1, no load pulse; done=1; pc=1.
- Fill all 16 words with 16'hD000. Run.
  - Expect: 16 load/s pulse pairs; done at pc=15; pc never wraps to 0.
- Model cpu holding w=1 after s.
  - Expect: err=1 exactly ACK_TIMEOUT cycles after WAIT_ACK entry; busy=0.
  - Then start → pc=0, err=0, busy=1.
- Assert reset while in WAIT_DONE at pc=5.
  - Expect: pc=0, busy=0, cpu_s=0 with no clock edge; RAM word 5 unchanged after reset.
- Pulse prog_we to addr 3 with 16'hABCD while busy.
  - Expect: mem[3] unchanged when later fetched.
  - Repeat in DONE → fetched value is 16'hABCD.
- With INSTR_SEQ_STEP_EN defined: two-instruction program.
  - Expect: after the first instruction the FSM sits in PAUSE with busy=1, pc=0.
  - One step edge → pc=1, second instruction issued.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// seq_pkg: shared types and constants for the instruction sequencer.
//   seq_state_e  - FSM state encoding (PAUSE only reachable with single-step support)
//   HALT_OPCODE  - opcode that ends a program
//   OPC_MSB/LSB  - opcode field position inside a 16-bit instruction word
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        ISSUE     = 3'd2,
        WAIT_ACK  = 3'd3,
        WAIT_DONE = 3'd4,
        DONE      = 3'd5,
        ERR       = 3'd6,
        PAUSE     = 3'd7
    } seq_state_e;

    localparam logic [2:0] HALT_OPCODE = 3'b111;
    localparam int         OPC_MSB     = 15;
    localparam int         OPC_LSB     = 13;

    function automatic logic is_halt(input logic [15:0] instr);
        return instr[OPC_MSB:OPC_LSB] == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: cpu handshake plus program-load bus.
//   cpu_in/cpu_load/cpu_s : sequencer -> cpu instruction issue
//   cpu_w                 : cpu -> sequencer wait flag (1 = cpu idle)
//   prog_we/addr/data     : host -> sequencer program RAM write port
// master = sequencer side, slave = cpu/host side.
interface instr_sequencer_if #(
    parameter int AW = 4
);
    logic [15:0]   cpu_in;
    logic          cpu_load;
    logic          cpu_s;
    logic          cpu_w;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [15:0]   prog_data;

    modport master (
        output cpu_in, cpu_load, cpu_s,
        input  cpu_w, prog_we, prog_addr, prog_data
    );

    modport slave (
        input  cpu_in, cpu_load, cpu_s,
        output cpu_w, prog_we, prog_addr, prog_data
    );
endinterface

// File: rtl/instr_sequencer_prog_ram.sv
// prog_ram: DEPTH x 16 program store, synchronous write, asynchronous read.
//   clk   - write clock
//   we    - write enable (already qualified by the caller)
//   waddr - write address, wdata - write data
//   raddr - read address, rdata - combinational read data
// Contents are not reset.
module prog_ram #(
    parameter int AW    = 4,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);
    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: feeds a program from local RAM to the cpu one instruction
// at a time (load pulse, start pulse, then wait for cpu_w to fall and rise).
// Ports:
//   clk, reset     - clock, asynchronous active-high reset
//   start          - run from pc 0 (accepted in IDLE/DONE/ERR)
//   step           - single-step advance, only with INSTR_SEQ_STEP_EN defined
//   bus (master)   - cpu handshake and program RAM write port
//   pc             - address of the current instruction
//   busy/done/err  - status decodes of the FSM state
// Build option: INSTR_SEQ_STEP_EN adds the step port and the PAUSE state.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | after reset, waiting for start; RAM writable
// FETCH     | mem[pc] on cpu_in; load pulse unless it is HALT
// ISSUE     | start pulse to the cpu, ack timer cleared
// WAIT_ACK  | waiting for cpu_w to fall, bounded by ACK_TIMEOUT
// WAIT_DONE | cpu executing; advance pc when cpu_w rises again
// DONE      | HALT fetched or last word executed; RAM writable
// ERR       | cpu never acknowledged; sticky until start/reset
// PAUSE     | single-step hold between instructions (step build only)
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int AW          = 4,
    parameter int DEPTH       = 16,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
`ifdef INSTR_SEQ_STEP_EN
    input  logic          step,
`endif
    instr_sequencer_if.master bus,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done,
    output logic          err
);
    localparam int            CW      = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [CW-1:0] TO_LAST = CW'(ACK_TIMEOUT - 1);
    localparam logic [AW-1:0] PC_LAST = AW'(DEPTH - 1);

    seq_state_e    state, state_nxt;
    logic [AW-1:0] pc_nxt;
    logic [CW-1:0] ack_cnt, ack_cnt_nxt;
    logic [15:0]   instr;
    logic          ram_we;

    // Programming is only safe while nothing is being issued.
    assign ram_we = bus.prog_we && (state == IDLE || state == DONE || state == ERR);

    prog_ram #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_prog_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (bus.prog_addr),
        .wdata (bus.prog_data),
        .raddr (pc),
        .rdata (instr)
    );

`ifdef INSTR_SEQ_STEP_EN
    logic step_q;
    logic step_rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end

    assign step_rise = step && !step_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pc      <= '0;
            ack_cnt <= '0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            ack_cnt <= ack_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        ack_cnt_nxt = ack_cnt;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_nxt = FETCH;
                    pc_nxt    = '0;
                end
            end
            FETCH: begin
                state_nxt = is_halt(instr) ? DONE : ISSUE;
            end
            ISSUE: begin
                state_nxt   = WAIT_ACK;
                ack_cnt_nxt = '0;
            end
            WAIT_ACK: begin
                if (!bus.cpu_w) begin
                    state_nxt = WAIT_DONE;
                end else if (ack_cnt == TO_LAST) begin
                    state_nxt = ERR;
                end else begin
                    ack_cnt_nxt = ack_cnt + CW'(1);
                end
            end
            WAIT_DONE: begin
                if (bus.cpu_w) begin
                    // End of RAM terminates the program; pc never wraps.
                    if (pc == PC_LAST) begin
                        state_nxt = DONE;
                    end else begin
`ifdef INSTR_SEQ_STEP_EN
                        state_nxt = PAUSE;
`else
                        state_nxt = FETCH;
                        pc_nxt    = pc + AW'(1);
`endif
                    end
                end
            end
`ifdef INSTR_SEQ_STEP_EN
            PAUSE: begin
                if (step_rise) begin
                    state_nxt = FETCH;
                    pc_nxt    = pc + AW'(1);
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.cpu_in   = instr;
    assign bus.cpu_load = (state == FETCH) && !is_halt(instr);
    assign bus.cpu_s    = (state == ISSUE);
    assign busy         = (state == FETCH) || (state == ISSUE) || (state == WAIT_ACK) ||
                          (state == WAIT_DONE) || (state == PAUSE);
    assign done         = (state == DONE);
    assign err          = (state == ERR);
endmodule

// File: tb/tb_instr_sequencer.sv
// Testbench for instr_sequencer: table-driven program runs, directed corner
// sequences (timeout, async reset, guarded writes, step) and randomized runs
// checked against a program-walk reference model.
module tb_instr_sequencer;
    import seq_pkg::*;

    localparam int AW          = 4;
    localparam int DEPTH       = 16;
    localparam int ACK_TIMEOUT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
`ifdef INSTR_SEQ_STEP_EN
    logic          step;
`endif
    logic [AW-1:0] pc;
    logic          busy, done, err;

    instr_sequencer_if #(.AW(AW)) bus ();

    instr_sequencer #(
        .AW          (AW),
        .DEPTH       (DEPTH),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
`ifdef INSTR_SEQ_STEP_EN
        .step  (step),
`endif
        .bus   (bus),
        .pc    (pc),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural cpu: drops w the cycle after s, keeps it low exec_len cycles.
    int exec_len = 3;
    bit cpu_hang = 1'b0;
    int cpu_cnt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.cpu_w <= 1'b1;
            cpu_cnt   <= 0;
        end else if (bus.cpu_s && !cpu_hang) begin
            bus.cpu_w <= 1'b0;
            cpu_cnt   <= exec_len;
        end else if (!bus.cpu_w) begin
            if (cpu_cnt <= 1) bus.cpu_w <= 1'b1;
            else cpu_cnt <= cpu_cnt - 1;
        end
    end

    // Issue log
    logic [15:0] load_q[$];
    int          load_pc_q[$];
    int          s_cnt;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.cpu_load) begin
                load_q.push_back(bus.cpu_in);
                load_pc_q.push_back(int'(pc));
            end
            if (bus.cpu_s) s_cnt++;
        end
    end

    logic [15:0] ref_mem [DEPTH];

    typedef struct {
        int halt_pos;   // DEPTH = no HALT in program
        int lat;
        int exp_loads;
        int exp_pc;
        int exp_cycles;
    } vec_t;
    vec_t tbl[5];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        load_q.delete();
        load_pc_q.delete();
        s_cnt = 0;
    endtask

    task automatic write_word(input int a, input logic [15:0] d);
        bus.prog_we   = 1'b1;
        bus.prog_addr = AW'(a);
        bus.prog_data = d;
        tick();
        bus.prog_we   = 1'b0;
    endtask

    task automatic load_program();
        for (int i = 0; i < DEPTH; i++) write_word(i, ref_mem[i]);
    endtask

    // Walk the program as the cpu would see it.
    task automatic model_expect(output int n, output int fpc, output int cyc);
        int p;
        n = 0;
        p = 0;
        forever begin
            if (ref_mem[p][15:13] == 3'b111) begin
                fpc = p;
                cyc = n * (exec_len + 3) + 1;
                break;
            end
            n++;
            if (p == DEPTH - 1) begin
                fpc = p;
                cyc = n * (exec_len + 3);
                break;
            end
            p++;
        end
    endtask

    task automatic run_to_done(input bit noise, output int cycles);
        clear_log();
        start = 1'b1;
        tick();
        start = 1'b0;
        cycles = 0;
        while (!done && !err && cycles < 3000) begin
            if (noise && busy) begin
                start         = ($urandom_range(0, 3) == 0);
                bus.prog_we   = ($urandom_range(0, 1) == 0);
                bus.prog_addr = AW'($urandom);
                bus.prog_data = 16'($urandom);
            end
`ifdef INSTR_SEQ_STEP_EN
            step = ~step;
`endif
            tick();
            start       = 1'b0;
            bus.prog_we = 1'b0;
            cycles++;
        end
        if (cycles >= 3000) check("run_bound", 0, 1);
    endtask

    task automatic compare_run(input string tag, input int cycles);
        int n, fpc, cyc;
        model_expect(n, fpc, cyc);
        check({tag, "_loads"}, load_q.size(), n);
        check({tag, "_s_pulses"}, s_cnt, n);
        for (int i = 0; i < n && i < load_q.size(); i++) begin
            check({tag, "_word"}, int'(load_q[i]), int'(ref_mem[i]));
            check({tag, "_load_pc"}, load_pc_q[i], i);
        end
        check({tag, "_pc"}, int'(pc), fpc);
        check({tag, "_done"}, int'(done), 1);
        check({tag, "_err"}, int'(err), 0);
`ifndef INSTR_SEQ_STEP_EN
        check({tag, "_cycles"}, cycles, cyc);
`endif
    endtask

    initial begin
        int cyc, n;

        tbl[0] = '{halt_pos: 0,     lat: 1, exp_loads: 0,  exp_pc: 0,  exp_cycles: 1};
        tbl[1] = '{halt_pos: 1,     lat: 3, exp_loads: 1,  exp_pc: 1,  exp_cycles: 7};
        tbl[2] = '{halt_pos: 5,     lat: 2, exp_loads: 5,  exp_pc: 5,  exp_cycles: 26};
        tbl[3] = '{halt_pos: DEPTH, lat: 1, exp_loads: 16, exp_pc: 15, exp_cycles: 64};
        tbl[4] = '{halt_pos: 10,    lat: 4, exp_loads: 10, exp_pc: 10, exp_cycles: 71};

        start         = 1'b0;
        bus.prog_we   = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
`ifdef INSTR_SEQ_STEP_EN
        step = 1'b0;
`endif
        reset = 1'b0;
        #1 reset = 1'b1;
        repeat (2) tick();
        check("rst_pc", int'(pc), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_load", int'(bus.cpu_load), 0);
        check("rst_s", int'(bus.cpu_s), 0);
        reset = 1'b0;
        tick();

        // Two-word program: MOV then HALT
        exec_len = 3;
        write_word(0, 16'hD007);
        write_word(1, 16'hE000);
        run_to_done(1'b0, cyc);
        check("a_loads", load_q.size(), 1);
        check("a_word", int'(load_q[0]), 16'hD007);
        check("a_s", s_cnt, 1);
        check("a_done", int'(done), 1);
        check("a_pc", int'(pc), 1);
`ifndef INSTR_SEQ_STEP_EN
        check("a_cycles", cyc, 7);
`endif

        // Table-driven program runs
        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < DEPTH; i++)
                ref_mem[i] = (i == tbl[t].halt_pos) ? 16'hE000 : 16'(16'hD000 + i);
            exec_len = tbl[t].lat;
            load_program();
            run_to_done(1'b0, cyc);
            check("tbl_loads", load_q.size(), tbl[t].exp_loads);
            check("tbl_s", s_cnt, tbl[t].exp_loads);
            check("tbl_pc", int'(pc), tbl[t].exp_pc);
            check("tbl_done", int'(done), 1);
`ifndef INSTR_SEQ_STEP_EN
            check("tbl_cycles", cyc, tbl[t].exp_cycles);
`endif
        end

        // Ack timeout: cpu never leaves Wait
        write_word(0, 16'hD000);
        cpu_hang = 1'b1;
        clear_log();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!bus.cpu_s && n < 20) begin tick(); n++; end
        check("to_s_seen", int'(bus.cpu_s), 1);
        tick();   // now in WAIT_ACK
        repeat (ACK_TIMEOUT - 1) tick();
        check("to_err_early", int'(err), 0);
        tick();
        check("to_err", int'(err), 1);
        check("to_busy", int'(busy), 0);
        tick();
        check("to_err_sticky", int'(err), 1);
        cpu_hang = 1'b0;
        write_word(1, 16'hE000);   // honoured in ERR
        start = 1'b1;
        tick();
        start = 1'b0;
        check("to_restart_pc", int'(pc), 0);
        check("to_restart_err", int'(err), 0);
        check("to_restart_busy", int'(busy), 1);
        n = 0;
        while (!done && n < 100) begin tick(); n++; end
        check("to_rerun_done", int'(done), 1);
        check("to_rerun_pc", int'(pc), 1);

        // Reset while executing pc 5
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'(16'hD000 + i);
        exec_len = 6;
        load_program();
        clear_log();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(pc == 5 && bus.cpu_s) && n < 500) begin
`ifdef INSTR_SEQ_STEP_EN
            step = ~step;
`endif
            tick();
            n++;
        end
        check("rs_at_pc5", int'(pc), 5);
        tick();
        tick();
        check("rs_busy_before", int'(busy), 1);
        #2 reset = 1'b1;
        #1;
        check("rs_pc", int'(pc), 0);
        check("rs_busy", int'(busy), 0);
        check("rs_s", int'(bus.cpu_s), 0);
        check("rs_load", int'(bus.cpu_load), 0);
        tick();
        reset = 1'b0;
        tick();
        run_to_done(1'b0, cyc);
        compare_run("rs_rerun", cyc);

        // Async drop of cpu_s while in ISSUE
        exec_len = 1;
        clear_log();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!bus.cpu_s && n < 20) begin tick(); n++; end
        #2 reset = 1'b1;
        #1 check("rs_issue_s", int'(bus.cpu_s), 0);
        tick();
        reset = 1'b0;
        tick();

        // Write while busy is ignored, write in DONE is taken
        exec_len = 2;
        clear_log();
        start = 1'b1;
        tick();
        start = 1'b0;
        write_word(3, 16'hABCD);
        n = 0;
        while (!done && n < 500) begin
`ifdef INSTR_SEQ_STEP_EN
            step = ~step;
`endif
            tick();
            n++;
        end
        check("wb_busy_word3", int'(load_q[3]), 16'hD003);
        write_word(3, 16'hABCD);
        ref_mem[3] = 16'hABCD;
        run_to_done(1'b0, cyc);
        check("wb_done_word3", int'(load_q[3]), 16'hABCD);
        compare_run("wb_done", cyc);

        // start and prog_we to address 0 in the same cycle: FETCH sees new word
        clear_log();
        bus.prog_we   = 1'b1;
        bus.prog_addr = '0;
        bus.prog_data = 16'hE123;
        start         = 1'b1;
        tick();
        bus.prog_we = 1'b0;
        start       = 1'b0;
        check("sw_busy", int'(busy), 1);
        tick();
        check("sw_done", int'(done), 1);
        check("sw_loads", load_q.size(), 0);
        check("sw_pc", int'(pc), 0);

        // Randomized programs with ignored writes/starts while busy
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                logic [15:0] w;
                w = 16'($urandom);
                if ($urandom_range(0, 6) == 0) w[15:13] = 3'b111;
                else if (w[15:13] == 3'b111) w[15] = 1'b0;
                ref_mem[i] = w;
            end
            exec_len = $urandom_range(1, 4);
            load_program();
            run_to_done(1'b1, cyc);
            compare_run("rnd", cyc);
        end

`ifdef INSTR_SEQ_STEP_EN
        // Single-step: hold in PAUSE until a step edge
        ref_mem[0] = 16'hD001;
        ref_mem[1] = 16'hD002;
        ref_mem[2] = 16'hE000;
        for (int i = 0; i < 3; i++) write_word(i, ref_mem[i]);
        exec_len = 2;
        step     = 1'b0;
        tick();
        clear_log();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        check("st_busy", int'(busy), 1);
        check("st_pc", int'(pc), 0);
        check("st_loads", load_q.size(), 1);
        step = 1'b1;
        tick();
        check("st_pc_step", int'(pc), 1);
        n = 0;
        while (load_q.size() < 2 && n < 20) begin tick(); n++; end
        check("st_word2", int'(load_q[1]), 16'hD002);
        step = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end
endmodule
